// File: rtl/address_unit.sv
// address_unit: PC, direct-low/high and indirect-low address registers plus the
// 16-bit memory address mux. Address registers load from the ALU result bus.
// Optional feature macro RESET_VECTOR_EN: after reset, fetch the PC from
// VECTOR_ADDR / VECTOR_ADDR+1 before normal operation (ready=0 while fetching).
module address_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        increment_pc,
  input  logic        pc_load,
  input  logic        indirl_load,
  input  logic        dirl_load,
  input  logic        dirh_load,
  input  logic [2:0]  address_select,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  data_in,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic        ready
);

  localparam logic [2:0] SEL_PC    = 3'd0;
  localparam logic [2:0] SEL_ZERO  = 3'd1;
  localparam logic [2:0] SEL_ABS   = 3'd2;
  localparam logic [2:0] SEL_IND0  = 3'd3;
  localparam logic [2:0] SEL_IND1  = 3'd4;

  logic [7:0] dirl, dirh, indirl;
  logic       vec_lo_we, vec_hi_we;
  logic [15:0] vec_addr;

`ifdef RESET_VECTOR_EN
  // The vector overwrites the PC, so it starts from zero instead of RESET_PC.
  localparam logic [15:0] PC_RST = 16'h0000;
  logic unused_ok;
  assign unused_ok = ^RESET_PC;

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} vstate_e;
  vstate_e state, state_nxt;

  // Vector-fetch state register; reset always restarts the fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= VEC_LO;
    else      state <= state_nxt;
  end

  // Vector-fetch sequencing: low byte, high byte, then run forever.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    vec_lo_we = 1'b0;
    vec_hi_we = 1'b0;
    vec_addr  = VECTOR_ADDR;
    case (state)
      VEC_LO: begin
        vec_lo_we = 1'b1;
        state_nxt = VEC_HI;
      end
      VEC_HI: begin
        vec_hi_we = 1'b1;
        vec_addr  = VECTOR_ADDR + 16'd1;
        state_nxt = RUN;
      end
      RUN:     ready = 1'b1;
      default: state_nxt = VEC_LO;
    endcase
  end
`else
  localparam logic [15:0] PC_RST = RESET_PC;
  logic unused_ok;
  assign unused_ok = ^{data_in, VECTOR_ADDR};
  assign ready     = 1'b1;
  assign vec_lo_we = 1'b0;
  assign vec_hi_we = 1'b0;
  assign vec_addr  = 16'h0000;
`endif

  // Operand address registers; several loads in one cycle share alu_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirl   <= 8'h00;
      dirh   <= 8'h00;
      indirl <= 8'h00;
    end else if (ready) begin
      if (dirl_load)   dirl   <= alu_result;
      if (dirh_load)   dirh   <= alu_result;
      if (indirl_load) indirl <= alu_result;
    end
  end

  // PC: vector bytes during fetch, else jump beats increment; jump sees old dirh/dirl.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           pc       <= PC_RST;
    else if (vec_lo_we) pc[7:0]  <= data_in;
    else if (vec_hi_we) pc[15:8] <= data_in;
    else if (ready) begin
      if (pc_load)           pc <= {dirh, dirl};
      else if (increment_pc) pc <= pc + 16'd1;
    end
  end

  // Address mux; the indirect high-byte pointer wraps inside the zero page.
  always_comb begin
    address = pc;
    case (address_select)
      SEL_PC:   address = pc;
      SEL_ZERO: address = {8'h00, dirl};
      SEL_ABS:  address = {dirh, dirl};
      SEL_IND0: address = {8'h00, indirl};
      SEL_IND1: address = {8'h00, indirl + 8'h01};
      default:  address = pc;
    endcase
    if (!ready) address = vec_addr;
  end

endmodule

// File: tb/tb_address_unit.sv
// Self-checking bench for address_unit (scoreboard of expected bus values).
module tb_address_unit;
  localparam logic [15:0] RST_PC_P = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        increment_pc, pc_load, indirl_load, dirl_load, dirh_load;
  logic [2:0]  address_select;
  logic [7:0]  alu_result, data_in;
  logic [15:0] address, pc;
  logic        ready;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] pc;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] base_pc;   // PC right after reset completes
  logic [15:0] rst_pc;    // PC while reset is held
  logic [15:0] rst_addr;  // address (sel=ABS) while reset is held
  logic        rst_rdy;

  address_unit #(.RESET_PC(RST_PC_P), .VECTOR_ADDR(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .increment_pc(increment_pc), .pc_load(pc_load),
    .indirl_load(indirl_load), .dirl_load(dirl_load), .dirh_load(dirh_load),
    .address_select(address_select), .alu_result(alu_result), .data_in(data_in),
    .address(address), .pc(pc), .ready(ready)
  );

  always #5 clk = ~clk;

  // Memory model for the reset vector.
  always_comb begin
    data_in = 8'h00;
    if (address == 16'hFFFC) data_in = 8'h00;
    else if (address == 16'hFFFD) data_in = 8'hC0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl;
    increment_pc = 0; pc_load = 0; indirl_load = 0; dirl_load = 0; dirh_load = 0;
    alu_result = 8'h00;
  endtask

  task automatic do_reset;
    clear_ctl();
    address_select = 3'd0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
`ifdef RESET_VECTOR_EN
    tick();
`endif
  endtask

  task automatic test_reset;
    clear_ctl();
    address_select = 3'd2;
    tick();
    rst = 1'b0;
    sb.push_back('{"reset_abs", rst_addr, rst_pc, rst_rdy});
    #1;
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
    do_reset();
  endtask

  task automatic test_pc_increment;
    address_select = 3'd0;
    increment_pc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{$sformatf("inc%0d", i), base_pc + 16'(i), base_pc + 16'(i), 1'b1});
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
      if (i < 3) tick();
    end
    increment_pc = 1'b0;
  endtask

  task automatic test_abs_zero;
    alu_result = 8'h34; dirl_load = 1'b1; tick(); dirl_load = 1'b0;
    alu_result = 8'h12; dirh_load = 1'b1; tick(); dirh_load = 1'b0;
    sb.push_back('{"abs", 16'h1234, base_pc + 16'd3, 1'b1});
    sb.push_back('{"zero", 16'h0034, base_pc + 16'd3, 1'b1});
    for (int s = 2; s >= 1; s--) begin
      address_select = 3'(s);
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
    end
  endtask

  task automatic test_indirect;
    logic [2:0]  sel[5];
    logic [7:0]  alu[5];
    logic [2:0]  ld[5];    // {indirl, dirh, dirl}
    logic [15:0] ea[5];
    sel = '{3'd3, 3'd4, 3'd4, 3'd2, 3'd3};
    alu = '{8'hFF, 8'hFF, 8'h7F, 8'hAB, 8'hAB};
    ld  = '{3'b100, 3'b000, 3'b100, 3'b111, 3'b000};
    ea  = '{16'h00FF, 16'h0000, 16'h0080, 16'hABAB, 16'h00AB};
    for (int i = 0; i < 5; i++) begin
      alu_result = alu[i];
      {indirl_load, dirh_load, dirl_load} = ld[i];
      if (ld[i] != 3'b000) tick();
      clear_ctl();
      address_select = sel[i];
      sb.push_back('{$sformatf("ind%0d", i), ea[i], base_pc + 16'd3, 1'b1});
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
    end
  endtask

  task automatic test_pc_priority;
    alu_result = 8'h00; dirl_load = 1'b1; tick(); dirl_load = 1'b0;
    alu_result = 8'h80; dirh_load = 1'b1; tick(); dirh_load = 1'b0;
    // Jump + increment + same-edge dirl reload: jump wins with the old dirl.
    pc_load = 1'b1; increment_pc = 1'b1; dirl_load = 1'b1; alu_result = 8'h55;
    tick();
    clear_ctl();
    sb.push_back('{"jump_pc", 16'h8000, 16'h8000, 1'b1});
    sb.push_back('{"jump_abs", 16'h8055, 16'h8000, 1'b1});
    for (int s = 0; s < 2; s++) begin
      address_select = (s == 0) ? 3'd0 : 3'd2;
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
    end
  endtask

  task automatic test_pc_wrap;
    alu_result = 8'hFF; dirl_load = 1'b1; dirh_load = 1'b1; tick();
    clear_ctl();
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    for (int s = 5; s < 8; s++) begin
      address_select = 3'(s);
      sb.push_back('{$sformatf("sel%0d_pc", s), 16'hFFFF, 16'hFFFF, 1'b1});
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
    end
    address_select = 3'd0;
    increment_pc = 1'b1; tick(); increment_pc = 1'b0;
    sb.push_back('{"wrap", 16'h0000, 16'h0000, 1'b1});
    tick();  // idle cycle: PC must hold
    sb.push_back('{"hold", 16'h0000, 16'h0000, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
    end
  endtask

  task automatic test_async_reset;
    // dirh/dirl are FF here; reset between edges must clear them at once.
    address_select = 3'd2;
    #2;
    rst = 1'b0;
    sb.push_back('{"async_abs", rst_addr, rst_pc, rst_rdy});
    #1;
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
    do_reset();
    address_select = 3'd3;
    sb.push_back('{"post_rst_ind", 16'h0000, base_pc, 1'b1});
    #1;
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
  endtask

`ifdef RESET_VECTOR_EN
  task automatic test_vector;
    tick();
    rst = 1'b0; #1; rst = 1'b1;
    // Controls must be ignored throughout the fetch.
    increment_pc = 1'b1; pc_load = 1'b1; dirl_load = 1'b1; alu_result = 8'h77;
    address_select = 3'd0;
    sb.push_back('{"vec_lo", 16'hFFFC, 16'h0000, 1'b0});
    sb.push_back('{"vec_hi", 16'hFFFD, 16'h0000, 1'b0});
    sb.push_back('{"vec_run", 16'hC000, 16'hC000, 1'b1});
    for (int i = 0; i < 3; i++) begin
      #1;
      e = sb.pop_front(); checks++;
      if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
                 e.name, address, pc, ready, e.addr, e.pc, e.rdy);
      end
      if (i < 2) tick();
    end
    clear_ctl();
    address_select = 3'd1;
    sb.push_back('{"vec_dirl_kept", 16'h0000, 16'hC000, 1'b1});
    #1;
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
    // Restart from inside VEC_HI.
    address_select = 3'd0;
    rst = 1'b0; #1; rst = 1'b1;
    tick();
    sb.push_back('{"restart_hi", 16'hFFFD, 16'h0000, 1'b0});
    #1;
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
    rst = 1'b0; #1;
    sb.push_back('{"restart_lo", 16'hFFFC, 16'h0000, 1'b0});
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
    rst = 1'b1;
    tick(); tick();
    sb.push_back('{"restart_run", 16'hC000, 16'hC000, 1'b1});
    e = sb.pop_front(); checks++;
    if (address !== e.addr || pc !== e.pc || ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: addr=%h pc=%h ready=%b, expected addr=%h pc=%h ready=%b",
               e.name, address, pc, ready, e.addr, e.pc, e.rdy);
    end
  endtask
`endif

  initial begin
`ifdef RESET_VECTOR_EN
    base_pc = 16'hC000; rst_pc = 16'h0000; rst_addr = 16'hFFFC; rst_rdy = 1'b0;
`else
    base_pc = RST_PC_P; rst_pc = RST_PC_P; rst_addr = 16'h0000; rst_rdy = 1'b1;
`endif
    clear_ctl();
    address_select = 3'd0;
    rst = 1'b0;
    #12;
    rst = 1'b1;
    do_reset();
    test_reset();
    test_pc_increment();
    test_abs_zero();
    test_indirect();
    test_pc_priority();
    test_pc_wrap();
    test_async_reset();
`ifdef RESET_VECTOR_EN
    test_vector();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
